adc_spi_emulator: RTL and testbench
===================================

Name: adc_spi_emulator

Overview:
- Parametrised successor to the bare SPI ADC stand-in: emulates a multi-channel MAX1113x-class SAR ADC serial port, entirely in the system clock domain.
- Oversamples nCS/SCLK; frames are 1 leading zero, DATA_W result bits MSB first, trailing zeros, then DOUT released.
- Per-channel ramp generators supply known sample values; channels scan round-robin.
- Sits on the FPGA test harness as the slave under the ADC-reader master.

Parameters:
- DATA_W, 12, result bits per sample.
- NUM_CH, 4, emulated channels (1..16); CH_W = max(1, clog2(NUM_CH)).
- FRAME_LEN, 16, SCLK falling edges per full frame; must be >= DATA_W+2.
- MIN_EDGES, 10, falling edges required before nCS rise for the frame to count as valid.
- RAMP_STEP, 1, base ramp increment; channel c steps by RAMP_STEP*(c+1).

Ports:
- CLK  in  1  system clock; must be >= 4x SCLK frequency.
- nRST  in  1  asynchronous active-low reset.
- nCS  in  1  chip select from master, async to CLK.
- SCLK  in  1  serial clock from master, async to CLK.
- DOUT  out  1  serial data.
- DOUT_OE  out  1  output enable for the top-level tri-state pad (1 = driving).
- CH_CUR  out  CH_W  channel sampled in the current/next frame.
- FRAME_DONE  out  1  one-CLK pulse on valid frame end.
- FRAME_ERR  out  1  one-CLK pulse on aborted frame end.

Behaviour:
- Reset: all outputs 0; ramps 0; CH_CUR 0; sync regs for nCS/SCLK reset to 1 (idle). If nCS is held low at reset release, a frame starts on the detected fall.
- Sync: 2-FF synchroniser per input plus 1 edge-detect reg; DOUT/DOUT_OE change exactly 3 CLK after the pin edge.
- States: IDLE, SHIFT, DONE_WAIT.
- IDLE, nCS fall: latch word = {0, ramp[CH_CUR], zeros} (FRAME_LEN-1 bits), bit_cnt=0, DOUT=0, DOUT_OE=1, go SHIFT.
- SHIFT, SCLK fall: bit_cnt++, DOUT = next word bit MSB first. The MSB of the result appears after fall 1; the LSB after fall DATA_W. When bit_cnt reaches FRAME_LEN-1, set DOUT_OE=0, DOUT=0 and go DONE_WAIT.
- SCLK rise: ignored except under SPI_CMD_EN.
- DONE_WAIT: further SCLK falls are ignored; bit_cnt saturates.
- nCS rise in SHIFT/DONE_WAIT: DOUT_OE=0, DOUT=0, go IDLE.
  - If falls >= MIN_EDGES: FRAME_DONE pulse, ramp[CH_CUR] += RAMP_STEP*(CH_CUR+1) mod 2^DATA_W, CH_CUR advances (NUM_CH-1 wraps to 0).
  - Else: FRAME_ERR pulse, no ramp or channel change.
- Simultaneous synced nCS rise and SCLK fall: nCS rise wins; the fall is not counted.
- nCS fall seen while not IDLE (glitch): ignored.
- Reset mid-frame: immediate return to reset state, DOUT_OE=0.

Optional Feature:
- Macro SPI_CMD_EN.
- Defined: adds input DIN (1 bit, async, same 2-FF sync). DIN is sampled on synced SCLK rises 1..1+CH_W of each frame.
  - Bit 1 = manual flag; next CH_W bits = channel, MSB first.
  - On a valid frame end with flag=1 and channel < NUM_CH, CH_CUR loads that channel instead of incrementing. Otherwise auto-increment applies.
  - Aborted frames discard the command.
- Undefined: no DIN port; pure round-robin.

Test Plan:
- Reset, then 4 full 16-edge frames at SCLK=CLK/8 -> DOUT words 0x0000 each (ramps 0), CH_CUR 0,1,2,3, four FRAME_DONE pulses.
- Second scan of 4 frames -> results ch0=1, ch1=2, ch2=3, ch3=4 (word = result<<2); DOUT_OE low 3 CLK after the 16th fall.
- nCS raised after 6 falls -> FRAME_ERR pulse, CH_CUR unchanged, same value re-sent next frame.
- nCS raised after exactly 10 falls -> FRAME_DONE, ramp advances; DOUT_OE drops 3 CLK after nCS rise.
- Ramp wrap: ch0 ramp at 0xFFF, valid frame -> next ch0 frame reads 0x000.
- SPI_CMD_EN: DIN bits 1,1,0 in frame on ch0 (NUM_CH=4) -> next CH_CUR=2; channel 3 with NUM_CH=3 -> ignored, auto-increment; nRST asserted at fall 5 -> DOUT_OE=0 immediately, CH_CUR=0.

Source files
------------

// File: rtl/adc_spi_emulator.sv
// rtl/adc_spi_emulator.sv - multi-channel SAR ADC serial port emulator with per-channel ramp sources
//
// Optional feature macro: SPI_CMD_EN
//   When defined, an i_din input is added and a per-frame command selects the next channel.
//   When undefined, channels are scanned round-robin.
//
// Ports:
//   i_clk        system clock (at least 4x the SCLK rate)
//   i_nrst       asynchronous active-low reset
//   i_ncs        chip select from master, asynchronous to i_clk
//   i_sclk       serial clock from master, asynchronous to i_clk
//   i_din        (SPI_CMD_EN only) command data from master, asynchronous to i_clk
//   o_dout       serial result data
//   o_dout_oe    pad output enable, 1 = driving
//   o_ch_cur     channel sampled in the current/next frame
//   o_frame_done one-cycle pulse on a valid frame end
//   o_frame_err  one-cycle pulse on an aborted frame end
module adc_spi_emulator #(
    parameter int DATA_W    = 12,
    parameter int NUM_CH    = 4,
    parameter int FRAME_LEN = 16,
    parameter int MIN_EDGES = 10,
    parameter int RAMP_STEP = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic            i_ncs,
    input  logic            i_sclk,
`ifdef SPI_CMD_EN
    input  logic            i_din,
`endif
    output logic            o_dout,
    output logic            o_dout_oe,
    output logic [CH_W-1:0] o_ch_cur,
    output logic            o_frame_done,
    output logic            o_frame_err
);

    // Result bits plus trailing zeros; the leading zero is presented directly at frame start.
    localparam int WORD_W = FRAME_LEN - 2;
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] L_LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] L_MIN_CNT  = CNT_W'(MIN_EDGES);
    localparam logic [CH_W-1:0]  L_LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE_WAIT
    } state_t;

    logic [1:0]        r_ncs_sync;
    logic [1:0]        r_sclk_sync;
    logic              r_ncs_prev;
    logic              r_sclk_prev;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_dout;
    logic              r_dout_oe;
    logic [CH_W-1:0]   r_ch_cur;
    logic              r_frame_done;
    logic              r_frame_err;
    logic [DATA_W-1:0] r_ramp [NUM_CH];

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [WORD_W-1:0] w_word_nxt;
    logic              w_dout_nxt;
    logic              w_dout_oe_nxt;
    logic [CH_W-1:0]   w_ch_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_advance;

    logic              w_ncs_fall;
    logic              w_ncs_rise;
    logic              w_sclk_fall;
    logic [DATA_W-1:0] w_ramp_cur;
    logic [DATA_W-1:0] w_step;
    logic [WORD_W-1:0] w_word_load;
    logic [CH_W-1:0]   w_ch_auto;

    // Synchronisers idle high so a held-low nCS at reset release is seen as a fall.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_ncs_sync  <= 2'b11;
            r_sclk_sync <= 2'b11;
            r_ncs_prev  <= 1'b1;
            r_sclk_prev <= 1'b1;
        end else begin
            r_ncs_sync  <= {r_ncs_sync[0], i_ncs};
            r_sclk_sync <= {r_sclk_sync[0], i_sclk};
            r_ncs_prev  <= r_ncs_sync[1];
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    assign w_ncs_fall  = r_ncs_prev & ~r_ncs_sync[1];
    assign w_ncs_rise  = ~r_ncs_prev & r_ncs_sync[1];
    assign w_sclk_fall = r_sclk_prev & ~r_sclk_sync[1];

    assign w_ramp_cur  = r_ramp[r_ch_cur];
    assign w_step      = DATA_W'(RAMP_STEP * (32'(r_ch_cur) + 1));
    assign w_word_load = WORD_W'(w_ramp_cur) << (WORD_W - DATA_W);
    assign w_ch_auto   = (r_ch_cur == L_LAST_CH) ? '0 : r_ch_cur + CH_W'(1);

`ifdef SPI_CMD_EN
    logic [1:0]      r_din_sync;
    logic [2:0]      r_rise_cnt;
    logic            r_cmd_flag;
    logic [CH_W-1:0] r_cmd_ch;
    logic            w_sclk_rise;
    logic            w_cmd_ok;

    assign w_sclk_rise = ~r_sclk_prev & r_sclk_sync[1];
    assign w_cmd_ok    = r_cmd_flag && (32'(r_cmd_ch) < NUM_CH);

    // Rise 1 carries the manual flag, rises 2..1+CH_W the channel MSB first.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_din_sync <= 2'b00;
            r_rise_cnt <= '0;
            r_cmd_flag <= 1'b0;
            r_cmd_ch   <= '0;
        end else begin
            r_din_sync <= {r_din_sync[0], i_din};
            if (r_state == S_IDLE) begin
                if (w_ncs_fall) begin
                    r_rise_cnt <= '0;
                    r_cmd_flag <= 1'b0;
                    r_cmd_ch   <= '0;
                end
            end else if (w_sclk_rise && !w_ncs_rise) begin
                if (r_rise_cnt != 3'd7) begin
                    r_rise_cnt <= r_rise_cnt + 3'd1;
                end
                if (r_rise_cnt == 3'd0) begin
                    r_cmd_flag <= r_din_sync[1];
                end else if (32'(r_rise_cnt) <= CH_W) begin
                    r_cmd_ch <= CH_W'({r_cmd_ch, r_din_sync[1]});
                end
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_word_nxt    = r_word;
        w_dout_nxt    = r_dout;
        w_dout_oe_nxt = r_dout_oe;
        w_ch_nxt      = r_ch_cur;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_advance     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_ncs_fall) begin
                    w_word_nxt    = w_word_load;
                    w_bit_cnt_nxt = '0;
                    w_dout_nxt    = 1'b0;
                    w_dout_oe_nxt = 1'b1;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT, S_DONE_WAIT: begin
                // nCS rise takes priority over a coincident SCLK fall.
                if (w_ncs_rise) begin
                    w_dout_oe_nxt = 1'b0;
                    w_dout_nxt    = 1'b0;
                    w_state_nxt   = S_IDLE;
                    if (r_bit_cnt >= L_MIN_CNT) begin
                        w_done_nxt = 1'b1;
                        w_advance  = 1'b1;
`ifdef SPI_CMD_EN
                        w_ch_nxt   = w_cmd_ok ? r_cmd_ch : w_ch_auto;
`else
                        w_ch_nxt   = w_ch_auto;
`endif
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_sclk_fall && r_state == S_SHIFT) begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == L_LAST_CNT) begin
                        w_dout_oe_nxt = 1'b0;
                        w_dout_nxt    = 1'b0;
                        w_state_nxt   = S_DONE_WAIT;
                    end else begin
                        w_dout_nxt = r_word[WORD_W-1];
                        w_word_nxt = r_word << 1;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_dout_oe_nxt = 1'b0;
                w_dout_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_word       <= '0;
            r_dout       <= 1'b0;
            r_dout_oe    <= 1'b0;
            r_ch_cur     <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_word       <= w_word_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_oe    <= w_dout_oe_nxt;
            r_ch_cur     <= w_ch_nxt;
            r_frame_done <= w_done_nxt;
            r_frame_err  <= w_err_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_ramp[c] <= '0;
            end
        end else if (w_advance) begin
            r_ramp[r_ch_cur] <= w_ramp_cur + w_step;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_oe    = r_dout_oe;
    assign o_ch_cur     = r_ch_cur;
    assign o_frame_done = r_frame_done;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_adc_spi_emulator.sv
// tb/tb_adc_spi_emulator.sv - scoreboard bench for adc_spi_emulator
module tb_adc_spi_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic       ncs_a, sclk_a, ncs_b, sclk_b;
    logic       dout_a, oe_a, done_a, err_a;
    logic [1:0] ch_a;
    logic       dout_b, oe_b, done_b, err_b;
    logic       ch_b;
`ifdef SPI_CMD_EN
    logic        din_a, din_b;
    logic [15:0] din_seq_a;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          done;
        logic [14:0] word;
        int          nb;
        int          ch;
    } exp_t;
    exp_t sb[$];

    logic cap_bits [15];
    int   cap_n  = 0;
    int   cap_ch = 0;

    adc_spi_emulator u_dut_a (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_ncs       (ncs_a),
        .i_sclk      (sclk_a),
`ifdef SPI_CMD_EN
        .i_din       (din_a),
`endif
        .o_dout      (dout_a),
        .o_dout_oe   (oe_a),
        .o_ch_cur    (ch_a),
        .o_frame_done(done_a),
        .o_frame_err (err_a)
    );

    adc_spi_emulator #(
        .DATA_W   (4),
        .NUM_CH   (1),
        .FRAME_LEN(8),
        .MIN_EDGES(6),
        .RAMP_STEP(1)
    ) u_dut_b (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_ncs       (ncs_b),
        .i_sclk      (sclk_b),
`ifdef SPI_CMD_EN
        .i_din       (din_b),
`endif
        .o_dout      (dout_b),
        .o_dout_oe   (oe_b),
        .o_ch_cur    (ch_b),
        .o_frame_done(done_b),
        .o_frame_err (err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a();
`ifdef SPI_CMD_EN
        din_a     = din_seq_a[0];
        din_seq_a = din_seq_a >> 1;
`endif
        sclk_a = 1'b0;
        wait_clks(4);
        sclk_a = 1'b1;
        wait_clks(4);
    endtask

    // One master frame on DUT A; the expected response goes to the scoreboard first.
    task automatic frame_a(input int falls, input bit clash, input bit chk_rise,
                           input bit exp_done, input int res, input int ch);
        exp_t e;
        e.done = exp_done;
        e.word = 15'(res << 2);
        e.nb   = clash ? falls - 1 : ((falls > 15) ? 15 : falls);
        e.ch   = ch;
        sb.push_back(e);
        ncs_a = 1'b0;
        wait_clks(4);
        for (int k = 1; k <= falls; k++) begin
            if (clash && k == falls) begin
                ncs_a  = 1'b1;
                sclk_a = 1'b0;
                wait_clks(8);
                sclk_a = 1'b1;
            end else if (k == 16) begin
                sclk_a = 1'b0;
                @(posedge clk); @(posedge clk);
                #1 chk("oe_held_2clk_after_f16", oe_a, 1);
                @(posedge clk);
                #1 chk("oe_low_3clk_after_f16", oe_a, 0);
                chk("dout_low_after_f16", dout_a, 0);
                wait_clks(2);
                sclk_a = 1'b1;
                wait_clks(4);
            end else begin
                pulse_a();
            end
        end
        if (!clash) begin
            ncs_a = 1'b1;
            if (chk_rise) begin
                @(posedge clk); @(posedge clk);
                #1 chk("oe_held_2clk_after_ncs_rise", oe_a, 1);
                @(posedge clk);
                #1 chk("oe_low_3clk_after_ncs_rise", oe_a, 0);
            end
        end
        wait_clks(8);
    endtask

    task automatic frame_b(input int res, input string nm);
        logic [6:0] cap;
        bit         seen;
        cap  = '0;
        seen = 1'b0;
        ncs_b = 1'b0;
        wait_clks(4);
        for (int k = 1; k <= 8; k++) begin
            if (k <= 7) cap = {cap[5:0], dout_b};
            sclk_b = 1'b0;
            wait_clks(4);
            sclk_b = 1'b1;
            wait_clks(4);
        end
        ncs_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        chk({nm, "_word"}, 32'(cap), 32'(7'(res << 2)));
        chk({nm, "_done"}, 32'(seen), 1);
        wait_clks(4);
    endtask

    // Serial capture: DOUT is stable at each pin SCLK fall (it moves 3 CLK later).
    always @(negedge ncs_a) begin
        cap_n  = 0;
        cap_ch = int'(ch_a);
    end

    always @(negedge sclk_a) begin
        if (ncs_a == 1'b0 && cap_n < 15) begin
            cap_bits[cap_n] = dout_a;
            cap_n++;
        end
    end

    initial begin
        exp_t        e;
        logic [14:0] cw;
        forever begin
            @(negedge clk);
            if (done_a || err_a) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame_pulse", {30'd0, done_a, err_a}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("frame_done_pulse", 32'(done_a), 32'(e.done));
                    chk("frame_err_pulse", 32'(err_a), 32'(!e.done));
                    chk("frame_channel", cap_ch, e.ch);
                    chk("bits_captured", 32'(cap_n >= e.nb), 1);
                    cw = '0;
                    for (int i = 0; i < e.nb; i++) cw = {cw[13:0], cap_bits[i]};
                    chk("dout_word", 32'(cw), 32'(e.word >> (15 - e.nb)));
                end
            end
        end
    end

    initial begin
        nrst   = 1'b0;
        ncs_a  = 1'b1;
        sclk_a = 1'b1;
        ncs_b  = 1'b1;
        sclk_b = 1'b1;
`ifdef SPI_CMD_EN
        din_a     = 1'b0;
        din_b     = 1'b0;
        din_seq_a = '0;
`endif
        wait_clks(3);
        chk("rst_oe", oe_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_ch", 32'(ch_a), 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        nrst = 1'b1;
        wait_clks(4);

        for (int c = 0; c < 4; c++) frame_a(16, 1'b0, 1'b0, 1'b1, 0, c);
        for (int c = 0; c < 4; c++) frame_a(16, 1'b0, 1'b0, 1'b1, c + 1, c);

        frame_a(6, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("ch_kept_after_abort", 32'(ch_a), 0);
        frame_a(16, 1'b0, 1'b0, 1'b1, 2, 0);
        frame_a(10, 1'b0, 1'b1, 1'b1, 4, 1);
        frame_a(10, 1'b1, 1'b0, 1'b0, 6, 2);
        chk("ch_kept_after_clash", 32'(ch_a), 2);
        frame_a(16, 1'b0, 1'b0, 1'b1, 6, 2);
        frame_a(16, 1'b0, 1'b0, 1'b1, 8, 3);
        frame_a(16, 1'b0, 1'b0, 1'b1, 3, 0);

        ncs_a = 1'b0;
        wait_clks(4);
        for (int k = 1; k <= 4; k++) pulse_a();
        sclk_a = 1'b0;
        wait_clks(4);
        chk("oe_mid_frame", oe_a, 1);
        chk("ch_mid_frame", 32'(ch_a), 1);
        nrst = 1'b0;
        #1;
        chk("oe_after_mid_reset", oe_a, 0);
        chk("dout_after_mid_reset", dout_a, 0);
        chk("ch_after_mid_reset", 32'(ch_a), 0);
        ncs_a  = 1'b1;
        sclk_a = 1'b1;
        wait_clks(3);
        nrst = 1'b1;
        wait_clks(4);
        frame_a(16, 1'b0, 1'b0, 1'b1, 0, 0);
        frame_a(16, 1'b0, 1'b0, 1'b1, 0, 1);

`ifdef SPI_CMD_EN
        frame_a(16, 1'b0, 1'b0, 1'b1, 0, 2);
        frame_a(16, 1'b0, 1'b0, 1'b1, 0, 3);
        din_seq_a = 16'b011;
        frame_a(16, 1'b0, 1'b0, 1'b1, 1, 0);
        chk("cmd_loads_ch2", 32'(ch_a), 2);
        din_seq_a = '0;
        frame_a(16, 1'b0, 1'b0, 1'b1, 3, 2);
`endif

        for (int i = 0; i <= 16; i++) frame_b(i % 16, $sformatf("wrap_frame%0d", i));
        chk("single_ch_stays_0", 32'(ch_b), 0);
`ifdef SPI_CMD_EN
        din_b = 1'b1;
        frame_b(1, "cmd_invalid_frame");
        din_b = 1'b0;
        chk("cmd_invalid_ch_ignored", 32'(ch_b), 0);
`endif

        wait_clks(10);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
